// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong game types and default sizes
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int WIN_SCORE_DEF = 7;
    localparam int SCORE_W_DEF   = 4;

endpackage

// File: rtl/pause_timer.sv
// rtl/pause_timer.sv - loadable down-counter with a registered zero flag
module pause_timer #(
    parameter int W = 25
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] r_count;
    logic         r_done;

    // done trails the zero count by one cycle, giving value+2 cycles from load to done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_count <= value;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_count == '0);
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign done = r_done;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong point counter, serve pacing and win flags
module score_keeper
    import pong_pkg::*;
#(
    parameter int          WIN_SCORE    = WIN_SCORE_DEF,
    parameter int          SCORE_W      = SCORE_W_DEF,
    parameter int unsigned PAUSE_CYCLES = 32'd1 << 24
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               serve,
    output logic               ball_active,
    output logic               left,
    output logic               right
);

    localparam int                 PCW        = $clog2(PAUSE_CYCLES + 1);
    localparam logic [PCW-1:0]     PAUSE_LOAD = PCW'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_t             r_state;
    state_t             w_next_state;
    logic [SCORE_W-1:0] r_score_left, r_score_right;
    logic               r_serve, r_ball_active, r_left, r_right;
    logic [SCORE_W-1:0] w_score_left_nxt, w_score_right_nxt;
    logic               w_serve_nxt, w_ball_active_nxt, w_left_nxt, w_right_nxt;
    logic [SCORE_W-1:0] w_left_inc, w_right_inc;
    logic               w_miss_one, w_left_wins, w_right_wins;
    logic               w_timer_load, w_timer_done, w_new_game;

    assign w_miss_one   = miss_left ^ miss_right;
    assign w_left_inc   = r_score_left + 1'b1;
    assign w_right_inc  = r_score_right + 1'b1;
    assign w_left_wins  = w_miss_one && miss_right && (w_left_inc == WIN);
    assign w_right_wins = w_miss_one && miss_left && (w_right_inc == WIN);
    assign w_new_game   = start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    assign w_timer_load = (r_state == ST_PLAY) && (w_next_state == ST_PAUSE);

    pause_timer #(
        .W(PCW)
    ) u_pause_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_timer_load),
        .value   (PAUSE_LOAD),
        .done    (w_timer_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_SERVE;
            ST_SERVE: w_next_state = ST_PLAY;
            ST_PLAY: begin
                if (w_left_wins || w_right_wins) begin
                    w_next_state = ST_OVER;
                end else if (miss_left || miss_right) begin
                    w_next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: if (w_timer_done) w_next_state = ST_SERVE;
            ST_OVER:  if (start) w_next_state = ST_SERVE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every output is a plain register.
    always_comb begin
        w_score_left_nxt  = r_score_left;
        w_score_right_nxt = r_score_right;
        w_left_nxt        = r_left;
        w_right_nxt       = r_right;
        w_serve_nxt       = (w_next_state == ST_SERVE);
        w_ball_active_nxt = (w_next_state == ST_SERVE) || (w_next_state == ST_PLAY);
        if (w_new_game) begin
            w_score_left_nxt  = '0;
            w_score_right_nxt = '0;
            w_left_nxt        = 1'b0;
            w_right_nxt       = 1'b0;
        end else if ((r_state == ST_PLAY) && w_miss_one) begin
            if (miss_right) begin
                w_score_left_nxt = w_left_inc;
                w_left_nxt       = w_left_wins;
            end else begin
                w_score_right_nxt = w_right_inc;
                w_right_nxt       = w_right_wins;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_score_left  <= '0;
            r_score_right <= '0;
            r_serve       <= 1'b0;
            r_ball_active <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
        end else begin
            r_score_left  <= w_score_left_nxt;
            r_score_right <= w_score_right_nxt;
            r_serve       <= w_serve_nxt;
            r_ball_active <= w_ball_active_nxt;
            r_left        <= w_left_nxt;
            r_right       <= w_right_nxt;
        end
    end

    assign score_left  = r_score_left;
    assign score_right = r_score_right;
    assign serve       = r_serve;
    assign ball_active = r_ball_active;
    assign left        = r_left;
    assign right       = r_right;

endmodule
